key_msg_tx: RTL and testbench
=============================

KEY_MSG_TX -- requirements
Module: key_msg_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate.
REQ-003 Derived constant BAUD_DIV = CLK_FREQ/BAUD (integer truncation); parameters SHALL yield BAUD_DIV >= 2.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 key_pulse  input  1  one-cycle press strobe from the upstream debouncer, already in the clk domain.
REQ-007 tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-008 busy  output  1  high while a frame is in flight.
REQ-009 press_cnt  output  8  count of accepted presses.

Function
REQ-010 An accepted press SHALL start one 3-byte frame: 0xA5, then the new press_cnt value, then the checksum 0xA5 XOR that value.
REQ-011 A key_pulse in the IDLE state is accepted: press_cnt increments by 1, modulo 256 (0xFF wraps to 0x00), on the same edge.
REQ-012 A key_pulse while busy=1 SHALL be ignored: no count change and no queuing.
REQ-013 Frame FSM states: IDLE -> HDR -> CNT -> CHK -> IDLE. Each state advances only on the byte-done strobe of the transmitter.
REQ-014 Frame payload bytes SHALL be latched at acceptance. A later press_cnt change cannot alter a frame in flight.
REQ-015 Latency: key_pulse sampled high at edge N means tx=0 (start bit) and busy=1 from edge N+1.
REQ-016 Each bit (start, 8 data, stop) SHALL last exactly BAUD_DIV cycles, so one byte takes 10*BAUD_DIV cycles.
REQ-017 Bytes SHALL be sent back-to-back with no idle gap. The next start bit begins on the cycle after the previous stop bit ends.
REQ-018 A frame lasts exactly 30*BAUD_DIV cycles. busy SHALL drop on the cycle after the final stop bit completes.
REQ-019 A key_pulse on the first cycle busy=0 SHALL be accepted, giving a new frame with a 1-cycle idle-high gap.
REQ-020 tx SHALL be registered (glitch-free) and SHALL be high whenever no frame is in flight.

Reset
REQ-021 While rst_n=0 at a clk edge: tx=1, busy=0, press_cnt=0x00, frame FSM=IDLE, transmitter idle, baud and bit counters=0.
REQ-022 Reset mid-frame SHALL abort immediately. tx returns high on the next edge, and no partial byte resumes after reset release.
REQ-023 A key_pulse coincident with rst_n=0 SHALL be ignored.

Structure
REQ-024 Package key_uart_pkg SHALL hold the constants HDR_BYTE=8'hA5 and FRAME_LEN=3, and the frame FSM state enum.
REQ-025 Sub-module uart_tx SHALL provide the serializer, with the following interface:
- inputs: clk, rst_n, start, data[7:0]
- outputs: tx, done
- done is a one-cycle strobe at the end of the stop bit.
- parameter BAUD_DIV.
- internal states: IDLE, START, DATA, STOP.
REQ-026 key_msg_tx SHALL contain the frame FSM, press counter, payload latch and checksum XOR. It SHALL instantiate exactly one uart_tx.

Verification (CLK_FREQ=1000, BAUD=100, BAUD_DIV=10)
REQ-027 Single press after reset:
- stimulus: key_pulse at cycle 5.
- required: tx low for cycles 6-15; bytes decode as A5, 01, A4; busy high cycles 6-305; press_cnt=1.
REQ-028 Press while busy:
- stimulus: a second key_pulse 50 cycles into a frame.
- required: no extra frame; press_cnt unchanged; tx matches the single-press waveform.
REQ-029 Wrap-around:
- stimulus: 256 presses, each after busy falls.
- required: final frame is A5, 00, A5; press_cnt=0x00.
REQ-030 Back-to-back:
- stimulus: key_pulse on the first cycle busy=0.
- required: next start bit exactly 1 idle cycle after the previous stop bit; second frame carries count+1.
REQ-031 Reset mid-frame:
- stimulus: rst_n=0 during byte 2.
- required: tx=1, busy=0, press_cnt=0 on the next edge. After release, a press yields A5, 01, A4.
REQ-032 Bit timing check: every tx level in a frame holds for a multiple of 10 cycles; the stop bit is exactly 10 cycles high.

Source files
------------

// File: rtl/key_uart_pkg.sv
// Shared constants, frame FSM states and frame byte helper for the key press UART messenger.
package key_uart_pkg;

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam int         FRAME_LEN = 3;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    CNT,
    CHK
  } frame_state_t;

  // Byte idx of a frame carrying count cnt: header, count, then header XOR count.
  function automatic logic [7:0] frame_byte(input int idx, input logic [7:0] cnt);
    if (idx == 0) begin
      return HDR_BYTE;
    end else if (idx == FRAME_LEN - 1) begin
      return HDR_BYTE ^ cnt;
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART serializer, LSB first, idle high; a start during the last stop cycle chains the next byte.
module uart_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int            CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  tx_state_t     state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_q, tx_nxt;
  logic          tick;

  assign tick = (baud_cnt == LAST_TICK);
  assign done = (state == STOP) && tick;
  assign tx   = tx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      tx_q     <= tx_nxt;
    end
  end

  // tx_nxt is the level of the bit that begins on the coming edge, so tx stays registered.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    tx_nxt    = tx_q;
    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        baud_nxt = '0;
        if (start) begin
          state_nxt = START;
          shift_nxt = data;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
          tx_nxt    = shift[0];
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt   = bit_cnt + 3'd1;
            shift_nxt = {1'b0, shift[7:1]};
            tx_nxt    = shift[1];
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          baud_nxt = '0;
          if (start) begin
            state_nxt = START;
            shift_nxt = data;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/key_msg_tx.sv
// Sends a 3-byte UART frame (A5, press count, checksum) for every key press accepted while idle.
module key_msg_tx
  import key_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_pulse,
  output logic       tx,
  output logic       busy,
  output logic [7:0] press_cnt
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;

  frame_state_t state, state_nxt;
  logic [7:0]   cnt_q;
  logic [7:0]   cnt_inc;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         byte_done;
  logic         accept;

  assign accept  = (state == IDLE) && key_pulse;
  assign cnt_inc = press_cnt + 8'd1;
  assign busy    = (state != IDLE);

  // The serializer starts on the accepting edge itself, and each following byte is
  // requested on the stop bit's last cycle so bytes run back-to-back.
  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    tx_data   = frame_byte(0, cnt_q);
    case (state)
      IDLE: begin
        if (key_pulse) begin
          tx_start  = 1'b1;
          state_nxt = HDR;
        end
      end
      HDR: begin
        tx_data = frame_byte(1, cnt_q);
        if (byte_done) begin
          tx_start  = 1'b1;
          state_nxt = CNT;
        end
      end
      CNT: begin
        tx_data = frame_byte(2, cnt_q);
        if (byte_done) begin
          tx_start  = 1'b1;
          state_nxt = CHK;
        end
      end
      CHK: begin
        if (byte_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cnt_q freezes the frame's count so later press_cnt changes cannot touch it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      press_cnt <= 8'h00;
      cnt_q     <= 8'h00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        press_cnt <= cnt_inc;
        cnt_q     <= cnt_inc;
      end
    end
  end

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .start(tx_start),
    .data (tx_data),
    .tx   (tx),
    .done (byte_done)
  );

endmodule

// File: tb/tb_key_msg_tx.sv
// Self-checking bench for key_msg_tx: reset, aborted frame, then 256 randomly spaced presses through count wrap.
module tb_key_msg_tx;
  import key_uart_pkg::*;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD      = 100;
  localparam int BAUD_DIV  = CLK_FREQ / BAUD;
  localparam int FRAME_CYC = FRAME_LEN * 10 * BAUD_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_pulse = 1'b0;
  logic       tx;
  logic       busy;
  logic [7:0] press_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'h00;
  logic [7:0] last_bytes [3];

  always #5 clk = ~clk;

  key_msg_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_pulse(key_pulse),
    .tx       (tx),
    .busy     (busy),
    .press_cnt(press_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic kp, input logic rn);
    key_pulse = kp;
    rst_n     = rn;
    tick();
    key_pulse = 1'b0;
  endtask

  function automatic logic [7:0] modelByte(input int k, input logic [7:0] c);
    if (k == 0) return 8'hA5;
    if (k == 1) return c;
    return 8'hA5 ^ c;
  endfunction

  // Expected line level i cycles after acceptance: start 0, data LSB first, stop 1.
  function automatic logic modelLevel(input int i, input logic [7:0] c);
    int         bit_no;
    int         b;
    logic [7:0] byt;
    bit_no = i / BAUD_DIV;
    b      = bit_no % 10;
    byt    = modelByte(bit_no / 10, c);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return byt[b-1];
  endfunction

  task automatic pressAndCheck(input int interfere_at, input int abort_at);
    logic       cap_tx [FRAME_CYC];
    int         wave_bad;
    int         busy_bad;
    int         runs_bad;
    int         run_len;
    logic [7:0] dec;
    applyStimulus(1'b1, 1'b1);
    exp_cnt = exp_cnt + 8'd1;
    checkOutput("press_cnt_accept", {24'd0, press_cnt}, {24'd0, exp_cnt});
    wave_bad = 0;
    busy_bad = 0;
    for (int i = 0; i < abort_at; i++) begin
      cap_tx[i] = tx;
      if (tx !== modelLevel(i, exp_cnt)) wave_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (i == interfere_at) key_pulse = 1'b1;
      tick();
      key_pulse = 1'b0;
    end
    checkOutput("frame_wave", wave_bad, 0);
    checkOutput("frame_busy", busy_bad, 0);
    if (abort_at == FRAME_CYC) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        for (int j = 0; j < 8; j++) begin
          dec[j] = cap_tx[k * 10 * BAUD_DIV + (j + 1) * BAUD_DIV + BAUD_DIV / 2];
        end
        checkOutput($sformatf("byte%0d", k), {24'd0, dec}, {24'd0, modelByte(k, exp_cnt)});
        last_bytes[k] = dec;
      end
      runs_bad = 0;
      run_len  = 1;
      for (int i = 1; i < FRAME_CYC; i++) begin
        if (cap_tx[i] === cap_tx[i-1]) begin
          run_len++;
        end else begin
          if (run_len % BAUD_DIV != 0) runs_bad++;
          run_len = 1;
        end
      end
      if (run_len % BAUD_DIV != 0) runs_bad++;
      checkOutput("bit_timing", runs_bad, 0);
      checkOutput("busy_end", {31'd0, busy}, 32'd0);
      checkOutput("tx_idle_end", {31'd0, tx}, 32'd1);
      checkOutput("press_cnt_hold", {24'd0, press_cnt}, {24'd0, exp_cnt});
    end
  endtask

  initial begin
    int interfere;
    int gap;
    int resume_bad;
    $display("[TB] key_msg_tx bench start, BAUD_DIV=%0d", BAUD_DIV);

    // Presses during reset must be ignored.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_cnt", {24'd0, press_cnt}, 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b1);
    checkOutput("idle_tx", {31'd0, tx}, 32'd1);
    checkOutput("idle_cnt", {24'd0, press_cnt}, 32'd0);

    // Abort in the middle of the count byte.
    pressAndCheck(-1, FRAME_CYC / 2);
    rst_n = 1'b0;
    tick();
    checkOutput("abort_tx", {31'd0, tx}, 32'd1);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_cnt", {24'd0, press_cnt}, 32'd0);
    exp_cnt = 8'h00;
    rst_n   = 1'b1;
    resume_bad = 0;
    for (int i = 0; i < 2 * 10 * BAUD_DIV; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) resume_bad++;
      tick();
    end
    checkOutput("no_resume", resume_bad, 0);

    // First frame gets an ignored press 50 cycles in and is followed back-to-back.
    for (int f = 0; f < 256; f++) begin
      if (f == 0) begin
        interfere = 50;
      end else if ($urandom_range(0, 2) == 0) begin
        interfere = int'($urandom_range(0, FRAME_CYC - 1));
      end else begin
        interfere = -1;
      end
      pressAndCheck(interfere, FRAME_CYC);
      gap = (f == 0) ? 0 : int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b1);
    end

    checkOutput("wrap_hdr", {24'd0, last_bytes[0]}, 32'hA5);
    checkOutput("wrap_cnt", {24'd0, last_bytes[1]}, 32'h00);
    checkOutput("wrap_chk", {24'd0, last_bytes[2]}, 32'hA5);
    checkOutput("wrap_press_cnt", {24'd0, press_cnt}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
